// File: rtl/screen_mem_arbiter_if.sv
// Bundle of the CPU, VGA and screen-RAM ports around the screen memory arbiter.
// Pure wiring, no latency of its own.
// Backpressure: the CPU side is held by cpu_stall; the VGA side only sees grants.
interface screen_mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  // CPU memory-mapped screen access
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  // VGA character fetch
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  // Screen RAM port (synchronous read, data one cycle after issue)
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_stall, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment view (requesters plus RAM)
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_stall, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/screen_mem_arbiter.sv
// Shares the single-port screen RAM between the MIPS core and the VGA fetcher.
// Latency: CPU write 0 cycles, CPU read 1 stall cycle, VGA read data 1 cycle after grant.
// Backpressure: VGA wins by default; CPU is stalled, but wins after STARVE_LIMIT lost cycles.
module screen_mem_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  screen_mem_arbiter_if.slave    bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       vga_rvalid_q, vga_rvalid_d;

  logic cpu_elig;
  logic cpu_gnt;
  logic vga_gnt;

  // State registers: FSM, starvation counter and VGA read-data owner flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      vga_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      vga_rvalid_q <= vga_rvalid_d;
    end
  end

  // Grant decision, next state and all port outputs; everything forced quiet in reset
  always_comb begin
    state_d        = state_q;
    starve_d       = '0;
    vga_rvalid_d   = 1'b0;
    cpu_elig       = 1'b0;
    cpu_gnt        = 1'b0;
    vga_gnt        = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.vga_gnt    = 1'b0;
    bus.cpu_stall  = 1'b0;
    bus.cpu_rdata  = '0;
    bus.vga_rvalid = 1'b0;
    bus.vga_rdata  = '0;

    if (rst_ni) begin
      // A CPU read in flight blocks a second CPU issue, freeing the port for VGA
      cpu_elig = bus.cpu_req && (state_q == IDLE);
      cpu_gnt  = cpu_elig && (!bus.vga_req || (starve_q == LIMIT));
      vga_gnt  = bus.vga_req && !cpu_gnt;

      if (cpu_gnt) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
      end else if (vga_gnt) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.vga_addr;
      end

      // Writes retire in the grant cycle; reads release the CPU in the data cycle
      bus.cpu_stall = bus.cpu_req &&
                      !((cpu_gnt && bus.cpu_we) || (state_q == RD_WAIT));
      bus.vga_gnt   = vga_gnt;

      case (state_q)
        IDLE:    if (cpu_gnt && !bus.cpu_we) state_d = RD_WAIT;
        RD_WAIT: state_d = IDLE;
        default: state_d = IDLE;
      endcase

      // Count only cycles where the CPU could have gone but VGA took the slot
      if (cpu_elig && vga_gnt) begin
        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
      end

      vga_rvalid_d   = vga_gnt;
      bus.vga_rvalid = vga_rvalid_q;
      bus.vga_rdata  = vga_rvalid_q ? bus.mem_rdata : '0;
      bus.cpu_rdata  = (state_q == RD_WAIT) ? bus.mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Bench for screen_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model and a shadow memory.
module tb_screen_mem_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  screen_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Base content of every RAM word; the RAM stores deltas from it
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Screen RAM: synchronous read, write on issue
  bit [DW-1:0] ram_delta [0:(1<<AW)-1];
  bit [DW-1:0] ram_rd_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram_delta[bus.mem_addr] <= bus.mem_wdata ^ pat(bus.mem_addr);
      else            ram_rd_q <= ram_delta[bus.mem_addr] ^ pat(bus.mem_addr);
    end
  end
  assign bus.mem_rdata = ram_rd_q;

  int n_err    = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: what the CPU/VGA should observe, at transaction level
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_read_pending;   // CPU read issued last cycle, data due now
  int            m_lost;           // consecutive cycles the CPU lost to VGA
  bit            m_vga_pending;
  logic [DW-1:0] m_vga_data;
  logic [DW-1:0] m_cpu_data;
  bit            m_last_stall;

  // Outputs sampled at the last negedge, for directed constant checks
  logic          s_en, s_we, s_vgnt, s_stall, s_vrvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_vrdata, s_crdata;

  // One clock: compare at negedge, advance model, return #1 after posedge
  task automatic cycle();
    bit cpu_can, cpu_wins, vga_wins, e_stall;
    logic [AW-1:0] e_addr;
    bit            n_rp, n_vp;
    int            n_lost;
    logic [DW-1:0] n_vd, n_cd;
    @(negedge clk);
    s_en = bus.mem_en; s_we = bus.mem_we; s_vgnt = bus.vga_gnt;
    s_stall = bus.cpu_stall; s_vrvalid = bus.vga_rvalid; s_addr = bus.mem_addr;
    s_vrdata = bus.vga_rdata; s_crdata = bus.cpu_rdata;
    n_rp = 0; n_vp = 0; n_lost = 0; n_vd = '0; n_cd = '0;
    if (!rst_n) begin
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_vga_gnt", bus.vga_gnt, 0);
      chk("rst_cpu_stall", bus.cpu_stall, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_vga_rdata", bus.vga_rdata, 0);
      chk("rst_vga_rvalid", bus.vga_rvalid, 0);
      e_stall = 0;
    end else begin
      cpu_can  = bus.cpu_req && !m_read_pending;
      cpu_wins = cpu_can && (!bus.vga_req || m_lost == LIM);
      vga_wins = bus.vga_req && !cpu_wins;
      e_addr   = cpu_wins ? bus.cpu_addr : (vga_wins ? bus.vga_addr : '0);
      e_stall  = bus.cpu_req && !(cpu_wins && bus.cpu_we) && !m_read_pending;
      chk("mem_en", bus.mem_en, cpu_wins || vga_wins);
      chk("mem_we", bus.mem_we, cpu_wins && bus.cpu_we);
      chk("vga_gnt", bus.vga_gnt, vga_wins);
      chk("cpu_stall", bus.cpu_stall, e_stall);
      if (cpu_wins || vga_wins) chk("mem_addr", bus.mem_addr, e_addr);
      if (cpu_wins && bus.cpu_we) chk("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      chk("vga_rvalid", bus.vga_rvalid, m_vga_pending);
      chk("vga_rdata", bus.vga_rdata, m_vga_pending ? m_vga_data : '0);
      chk("cpu_rdata", bus.cpu_rdata, m_read_pending ? m_cpu_data : '0);
      if (cpu_wins && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (cpu_wins && !bus.cpu_we) begin n_rp = 1; n_cd = ref_mem[bus.cpu_addr]; end
      if (vga_wins) begin n_vp = 1; n_vd = ref_mem[bus.vga_addr]; end
      if (cpu_can && vga_wins) n_lost = (m_lost < LIM) ? m_lost + 1 : LIM;
    end
    @(posedge clk);
    #1;
    m_read_pending = n_rp; m_cpu_data = n_cd;
    m_vga_pending  = n_vp; m_vga_data = n_vd;
    m_lost = n_lost; m_last_stall = e_stall;
  endtask

  task automatic cpu_set(input bit req, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pat(AW'(i));
    m_read_pending = 0; m_lost = 0; m_vga_pending = 0;
    m_vga_data = '0; m_cpu_data = '0; m_last_stall = 0;

    // Reset with both requesters asking
    cpu_set(1, 0, 11'h003, '0);
    bus.vga_req = 1; bus.vga_addr = 11'h005;
    repeat (3) cycle();
    rst_n = 1;
    cpu_set(0, 0, '0, '0);
    cycle();
    chk("first_vgnt", s_vgnt, 1);
    chk("first_rvalid_before", s_vrvalid, 0);
    bus.vga_req = 0;
    cycle();
    chk("first_rvalid_after", s_vrvalid, 1);
    chk("first_vrdata", s_vrdata, pat(11'h005));

    // Uncontended write then read of 0x010
    cpu_set(1, 1, 11'h010, 32'hDEAD_BEEF);
    cycle();
    chk("wr_en", s_en, 1);
    chk("wr_we", s_we, 1);
    chk("wr_stall", s_stall, 0);
    cpu_set(1, 0, 11'h010, '0);
    cycle();
    chk("rd_stall_n", s_stall, 1);
    cycle();
    chk("rd_stall_n1", s_stall, 0);
    chk("rd_data", s_crdata, 32'hDEAD_BEEF);
    chk("rd_no_reissue", s_en, 0);
    cpu_set(0, 0, '0, '0);
    cycle();

    // Sustained VGA load: CPU read must win after LIM lost cycles
    bus.vga_req = 1; bus.vga_addr = 11'h007;
    cpu_set(1, 0, 11'h010, '0);
    for (int k = 0; k < LIM; k++) begin
      cycle();
      chk("starve_vgnt", s_vgnt, 1);
    end
    cycle();
    chk("starve_cpu_vgnt", s_vgnt, 0);
    chk("starve_cpu_addr", s_addr, 11'h010);
    chk("starve_cpu_we", s_we, 0);
    cycle();
    chk("starve_rvalid", s_vrvalid, 0);
    chk("starve_stall", s_stall, 0);
    chk("starve_vgnt_again", s_vgnt, 1);
    chk("starve_rdata", s_crdata, 32'hDEAD_BEEF);
    cpu_set(0, 0, '0, '0);
    bus.vga_req = 0;
    cycle();

    // Reset while a read is waiting for data
    cpu_set(1, 0, 11'h020, '0);
    cycle();
    chk("midrst_issue_stall", s_stall, 1);
    rst_n = 0;
    #1;
    chk("midrst_stall_now", bus.cpu_stall, 0);
    chk("midrst_rdata_now", bus.cpu_rdata, 0);
    cycle();
    rst_n = 1;
    cycle();
    chk("reissue_stall", s_stall, 1);
    cycle();
    chk("reissue_stall_n1", s_stall, 0);
    chk("reissue_rdata", s_crdata, pat(11'h020));
    cpu_set(0, 0, '0, '0);
    cycle();

    // Random traffic, CPU holds its request while stalled
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.cpu_req && m_last_stall)) begin
        if ($urandom_range(0, 3) < ((c < 1500) ? 1 : 3))
          cpu_set(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        else
          cpu_set(0, 0, '0, '0);
      end
      bus.vga_req  = ($urandom_range(0, 3) != 0);
      bus.vga_addr = AW'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
